blob_centroid: RTL
==================

Name: blob_centroid

Overview:
- Per-frame centroid engine between the colour-threshold stage and the initialize/tracking logic.
- Accumulates the pixel count and the x/y coordinate sums of thresholded pixels over one VGA frame.
- At vsync, snapshots the totals and runs an in-house sequential restoring divider to produce mean x/y and blob size.
- Replaces the free-running IP dividers with a deterministic, handshaked result.

Parameters:
- H_ACTIVE, 640: pixels with hcount >= H_ACTIVE are ignored.
- V_ACTIVE, 480: lines with vcount >= V_ACTIVE are ignored.
- MIN_SIZE, 16: minimum pixel count for a blob to be reported as found.

Ports:
- clk_65mhz  in  1  system pixel clock.
- reset  in  1  asynchronous, active-low reset.
- hcount  in  11  current pixel column from xvga.
- vcount  in  10  current line from xvga.
- vsync  in  1  active-high vertical sync from xvga.
- pixel_hit  in  1  threshold result for the current hcount/vcount.
- x_mean  out  11  centroid column, floor(sum_x/size).
- y_mean  out  10  centroid row, floor(sum_y/size).
- size  out  20  pixel count of the last completed frame.
- found  out  1  size >= MIN_SIZE for the last completed frame.
- result_valid  out  1  one-cycle pulse when outputs update.
- busy  out  1  high while the divider is running.

Behaviour:
- Reset (reset=0, async): all accumulators, snapshots, x_mean, y_mean, size, found, result_valid, busy = 0; FSM = ACCUM; vsync_d = 0.
- Hit qualification: pixel_hit && hcount<H_ACTIVE && vcount<V_ACTIVE && !vsync.
- Per qualified hit: acc_n += 1 (20 bit, saturates at 2^20-1); acc_x += hcount (32 bit); acc_y += vcount (32 bit). Sums cannot overflow for a 640x480 frame.
- Edge detect: vsync_d registers vsync. Cycle E is the first cycle with vsync=1 && vsync_d=0.
- At the clock edge ending cycle E:
  - snap_n/x/y <= acc_n/x/y, including a hit qualified in cycle E (always excluded because vsync=1).
  - Accumulators clear to 0.
  - FSM -> DIV; busy=1.
- Accumulation continues independently of FSM state.
- FSM states:
  - ACCUM: idle, busy=0.
  - DIV: two parallel 32-iteration restoring dividers (snap_x/snap_n, snap_y/snap_n), one quotient bit per cycle MSB-first; 32 cycles (E+1..E+32) -> DONE.
  - DONE: one cycle (E+33); outputs updated; result_valid=1; busy=0 from next cycle; -> ACCUM.
- Latency: result_valid high exactly in cycle E+33.
- Output update in DONE:
  - size <= snap_n; found <= (snap_n >= MIN_SIZE).
  - If found: x_mean <= quotient_x[10:0], y_mean <= quotient_y[9:0].
  - Otherwise x_mean and y_mean hold their previous values.
- Divide by zero (snap_n=0): divider still runs 32 cycles; quotients are discarded; found=0; size=0; means hold.
- New vsync edge while in DIV or DONE: abort, snapshot the new totals, restart DIV at iteration 0; no result_valid for the aborted frame.
- result_valid never asserts for two consecutive cycles.
- Reset mid-DIV: immediate return to reset state; no result_valid.

Test Plan:
- 4x4 hit square at x=100..103, y=50..53, vsync edge -> result_valid at E+33; size=16; x_mean=101; y_mean=51; found=1; busy high E+1..E+33.
- Empty frame after the above -> size=0, found=0, x_mean=101, y_mean=51 held; result_valid one pulse.
- Full frame (pixel_hit=1 everywhere, including hcount 640..1343 and vcount 480..805) -> size=307200, x_mean=319, y_mean=239, found=1.
- 15-pixel blob at column 10, rows 0..14 -> size=15, found=0, means unchanged.
- Second vsync edge forced 10 cycles after the first -> no pulse at first E+33; single pulse 33 cycles after the second edge, with the second frame's totals.
- reset pulsed low at E+20 -> all outputs 0 immediately; no result_valid; next frame computes normally.

Source files
------------

// File: rtl/blob_centroid.sv
`default_nettype none
// ============================================================================
//  Module   : blob_centroid
//  Purpose  : Per-frame centroid engine. Accumulates the pixel count and the
//             x/y coordinate sums of thresholded pixels over one VGA frame.
//             On the rising edge of vsync the totals are snapshotted and two
//             sequential restoring dividers (one quotient bit per cycle)
//             produce the mean column, mean row and blob size.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_65mhz     in   1   pixel clock
//    reset         in   1   asynchronous, active-low reset
//    hcount        in  11   current pixel column
//    vcount        in  10   current line
//    vsync         in   1   active-high vertical sync
//    pixel_hit     in   1   threshold result for hcount/vcount
//    x_mean        out 11   centroid column, floor(sum_x/size)
//    y_mean        out 10   centroid row, floor(sum_y/size)
//    size          out 20   pixel count of the last completed frame
//    found         out  1   size >= MIN_SIZE for the last completed frame
//    result_valid  out  1   one-cycle pulse when the outputs update
//    busy          out  1   high while a division is in flight
// ============================================================================
module blob_centroid #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int MIN_SIZE = 16
) (
  input  logic        clk_65mhz,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        vsync,
  input  logic        pixel_hit,
  output logic [10:0] x_mean,
  output logic [9:0]  y_mean,
  output logic [19:0] size,
  output logic        found,
  output logic        result_valid,
  output logic        busy
);

  localparam logic [10:0] c_h_active = H_ACTIVE[10:0];
  localparam logic [9:0]  c_v_active = V_ACTIVE[9:0];
  localparam logic [19:0] c_min_size = MIN_SIZE[19:0];
  localparam logic [19:0] c_n_max    = 20'hF_FFFF;
  localparam logic [4:0]  c_last_it  = 5'd31;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DIV   = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_vsync_d;

  // Running per-frame totals
  logic [19:0] r_acc_n;
  logic [31:0] r_acc_x;
  logic [31:0] r_acc_y;

  // Snapshot of the previous frame. The x/y snapshots double as the dividend
  // shift registers: the MSB is consumed each iteration and shifted out.
  logic [19:0] r_snap_n;
  logic [31:0] r_snap_x;
  logic [31:0] r_snap_y;

  // Divider partial remainders. The remainder is always below the divisor,
  // which fits in 20 bits, so 20 bits suffice.
  logic [19:0] r_rem_x;
  logic [19:0] r_rem_y;

  // Only the low quotient bits are ever reported; shifting 32 bits through
  // an 11/10-bit register leaves exactly quotient[10:0] / quotient[9:0].
  logic [10:0] r_quo_x;
  logic [9:0]  r_quo_y;
  logic [4:0]  r_iter;

  logic        w_hit;
  logic        w_vs_edge;
  logic        w_found;
  logic [20:0] w_diff_x;
  logic [20:0] w_diff_y;
  logic        w_qbit_x;
  logic        w_qbit_y;
  logic [19:0] w_rem_x_nxt;
  logic [19:0] w_rem_y_nxt;
  logic [10:0] w_quo_x_nxt;
  logic [9:0]  w_quo_y_nxt;

  assign w_hit     = pixel_hit && (hcount < c_h_active) && (vcount < c_v_active) && !vsync;
  assign w_vs_edge = vsync && !r_vsync_d;
  assign w_found   = (r_snap_n >= c_min_size);

  // ---------------------------------------------------------------------------
  // Restoring divider step. Trial value is {remainder, next dividend bit}.
  // Since remainder < divisor, trial < 2*divisor < 2^21, so a non-negative
  // difference never sets bit 20; bit 20 of the 21-bit difference is
  // therefore a clean borrow flag (set = trial < divisor = quotient bit 0).
  // ---------------------------------------------------------------------------
  assign w_diff_x    = {r_rem_x, r_snap_x[31]} - {1'b0, r_snap_n};
  assign w_qbit_x    = ~w_diff_x[20];
  assign w_rem_x_nxt = w_qbit_x ? w_diff_x[19:0] : {r_rem_x[18:0], r_snap_x[31]};
  assign w_quo_x_nxt = {r_quo_x[9:0], w_qbit_x};

  assign w_diff_y    = {r_rem_y, r_snap_y[31]} - {1'b0, r_snap_n};
  assign w_qbit_y    = ~w_diff_y[20];
  assign w_rem_y_nxt = w_qbit_y ? w_diff_y[19:0] : {r_rem_y[18:0], r_snap_y[31]};
  assign w_quo_y_nxt = {r_quo_y[8:0], w_qbit_y};

  // ---------------------------------------------------------------------------
  // Frame accumulators: run independently of the divider state. They clear
  // on the vsync edge; a hit in the edge cycle is never qualified because
  // vsync is already high, so nothing is lost by clearing to zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_65mhz or negedge reset) begin
    if (!reset) begin
      r_vsync_d <= 1'b0;
      r_acc_n   <= '0;
      r_acc_x   <= '0;
      r_acc_y   <= '0;
    end else begin
      r_vsync_d <= vsync;
      if (w_vs_edge) begin
        r_acc_n <= '0;
        r_acc_x <= '0;
        r_acc_y <= '0;
      end else if (w_hit) begin
        if (r_acc_n != c_n_max) begin
          r_acc_n <= r_acc_n + 20'd1;
        end
        r_acc_x <= r_acc_x + {21'd0, hcount};
        r_acc_y <= r_acc_y + {22'd0, vcount};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and divider datapath. A vsync edge in any state (including
  // mid-division) reloads the snapshot and restarts at iteration 0, which
  // silently drops the aborted frame's result.
  // Outputs are written on the edge that ends the final iteration so that
  // they are visible in the DONE cycle together with result_valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_65mhz or negedge reset) begin
    if (!reset) begin
      r_state      <= ACCUM;
      r_snap_n     <= '0;
      r_snap_x     <= '0;
      r_snap_y     <= '0;
      r_rem_x      <= '0;
      r_rem_y      <= '0;
      r_quo_x      <= '0;
      r_quo_y      <= '0;
      r_iter       <= '0;
      x_mean       <= '0;
      y_mean       <= '0;
      size         <= '0;
      found        <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (w_vs_edge) begin
        r_snap_n <= r_acc_n;
        r_snap_x <= r_acc_x;
        r_snap_y <= r_acc_y;
        r_rem_x  <= '0;
        r_rem_y  <= '0;
        r_quo_x  <= '0;
        r_quo_y  <= '0;
        r_iter   <= '0;
        busy     <= 1'b1;
        r_state  <= DIV;
      end else begin
        case (r_state)
          ACCUM: begin
            busy <= 1'b0;
          end
          DIV: begin
            r_snap_x <= {r_snap_x[30:0], 1'b0};
            r_snap_y <= {r_snap_y[30:0], 1'b0};
            r_rem_x  <= w_rem_x_nxt;
            r_rem_y  <= w_rem_y_nxt;
            r_quo_x  <= w_quo_x_nxt;
            r_quo_y  <= w_quo_y_nxt;
            r_iter   <= r_iter + 5'd1;
            if (r_iter == c_last_it) begin
              r_state      <= DONE;
              result_valid <= 1'b1;
              size         <= r_snap_n;
              found        <= w_found;
              // A zero or too-small blob keeps the previous centroid; this
              // also discards the meaningless divide-by-zero quotient.
              if (w_found) begin
                x_mean <= w_quo_x_nxt;
                y_mean <= w_quo_y_nxt;
              end
            end
          end
          DONE: begin
            busy    <= 1'b0;
            r_state <= ACCUM;
          end
          default: begin
            busy    <= 1'b0;
            r_state <= ACCUM;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
